// File: rtl/md_unit_pkg.sv
// Shared op encoding, default timing and helpers for the multiply/divide unit.
// Optional madd/maddu start ops are gated by MD_MADD_EN.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // keep=1 means the operation must leave hi/lo untouched (divide by zero)
    typedef struct packed {
        logic        keep;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic is_md_start(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU:                  return 1'b1;
`endif
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_md_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// md_arith: combinational 64-bit mult/div/accumulate result from latched operands.
// Latency: none (pure logic); no backpressure. Accumulate input exists only with MD_MADD_EN.
module md_arith
    import md_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MD_MADD_EN
    input  logic [63:0] acc,
`endif
    output md_res_t     res
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_res;
    logic [31:0] r_res;

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes through the same unsigned divider; 0x80000000
    // negates to itself, so the overflow case falls out as lo=0x80000000, hi=0.
    assign is_sdiv  = (op == MD_DIV);
    assign rs_neg   = is_sdiv && rs[31];
    assign rt_neg   = is_sdiv && rt[31];
    assign num      = rs_neg ? -rs : rs;
    assign den      = rt_neg ? -rt : rt;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign q_mag    = num / den_safe;
    assign r_mag    = num % den_safe;
    assign q_res    = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
    assign r_res    = rs_neg ? -r_mag : r_mag;

    always_comb begin
        res = '0;
        case (op)
            MD_MULT:  {res.hi, res.lo} = prod_s;
            MD_MULTU: {res.hi, res.lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                res.keep = (rt == 32'd0);
                res.lo   = q_res;
                res.hi   = r_res;
            end
`ifdef MD_MADD_EN
            MD_MADD:  {res.hi, res.lo} = acc + prod_s;
            MD_MADDU: {res.hi, res.lo} = acc + prod_u;
`endif
            default:  res.keep = 1'b1;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO, with busy counter and D-stage stall.
// Latency: result lands MULT_CYCLES/DIV_CYCLES edges after start; mthi/mtlo single edge.
// Backpressure: md_stall holds D while busy or starting; MD_MADD_EN adds madd/maddu.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  e_md_op,
    input  logic        e_valid,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_isdm,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_op_e      op;
    md_op_e      op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [3:0]  cnt;
    md_res_t     res;

    assign op       = md_op_e'(e_md_op);
    assign md_start = e_valid && is_md_start(op) && !md_busy;
    assign md_stall = d_isdm && (md_start || md_busy);
    assign md_rdata = (op == MD_MFHI) ? hi : lo;

    md_arith u_arith (
        .op  (op_q),
        .rs  (rs_q),
        .rt  (rt_q),
`ifdef MD_MADD_EN
        // hi/lo cannot change while busy, so the live value equals the start-edge sample
        .acc ({hi, lo}),
`endif
        .res (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            md_busy <= 1'b0;
            cnt     <= '0;
            op_q    <= MD_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
        end else if (md_start) begin
            op_q    <= op;
            rs_q    <= e_rs;
            rt_q    <= e_rt;
            cnt     <= is_md_div(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            md_busy <= 1'b1;
        end else if (md_busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                md_busy <= 1'b0;
                if (!res.keep) begin
                    hi <= res.hi;
                    lo <= res.lo;
                end
            end
        end else if (e_valid) begin
            if (op == MD_MTHI) begin
                hi <= e_rs;
            end else if (op == MD_MTLO) begin
                lo <= e_rs;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized and directed bench for md_unit against a cycle-level behavioural model.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  e_md_op = 4'd0;
    logic        e_valid = 1'b0;
    logic [31:0] e_rs = '0;
    logic [31:0] e_rt = '0;
    logic        d_isdm = 1'b0;
    logic        md_start;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .e_md_op  (e_md_op),
        .e_valid  (e_valid),
        .e_rs     (e_rs),
        .e_rt     (e_rt),
        .d_isdm   (d_isdm),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: architectural hi/lo, cycles still to run, pending result
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    bit          p_keep = 1'b0;
    int          m_left = 0;
    bit          last_stall;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit starts(input logic [3:0] op);
`ifdef MD_MADD_EN
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
`else
        return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
    endfunction

    task automatic compute(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      sp;
        logic [63:0] up;
        int          a;
        int          b;
        a = int'(rs);
        b = int'(rt);
        sp = longint'(a) * longint'(b);
        up = {32'd0, rs} * {32'd0, rt};
        p_keep = 1'b0;
        case (op)
            4'd1: {p_hi, p_lo} = sp;
            4'd2: {p_hi, p_lo} = up;
            4'd3: begin
                if (b == 0) p_keep = 1'b1;
                else if (rs == 32'h8000_0000 && b == -1) begin
                    p_lo = 32'h8000_0000;
                    p_hi = 32'h0;
                end else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
            end
            4'd4: begin
                if (rt == 0) p_keep = 1'b1;
                else begin
                    p_lo = rs / rt;
                    p_hi = rs % rt;
                end
            end
            4'd9:  {p_hi, p_lo} = {m_hi, m_lo} + sp;
            4'd10: {p_hi, p_lo} = {m_hi, m_lo} + up;
            default: p_keep = 1'b1;
        endcase
    endtask

    // one clock: drive inputs, check outputs mid-cycle, advance model at the edge
    task automatic cyc(input logic [3:0] op, input bit v, input logic [31:0] rs,
                       input logic [31:0] rt, input bit dm);
        bit exp_start;
        e_md_op = op;
        e_valid = v;
        e_rs    = rs;
        e_rt    = rt;
        d_isdm  = dm;
        #3;
        exp_start = v && starts(op) && (m_left == 0);
        check("md_start", md_start, exp_start);
        check("md_busy", md_busy, m_left != 0);
        check("md_stall", md_stall, dm && (exp_start || m_left != 0));
        check("md_rdata", md_rdata, (op == 4'd5) ? m_hi : m_lo);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        last_stall = md_stall;
        last_rdata = md_rdata;
        @(posedge clk);
        if (exp_start) begin
            compute(op, rs, rt);
            m_left = (op == 4'd3 || op == 4'd4) ? DC : MC;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && !p_keep) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (v && op == 4'd7) m_hi = rs;
        else if (v && op == 4'd8) m_lo = rs;
        #1;
    endtask

    task automatic idle(input int n, input bit dm);
        for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, 32'd0, 32'd0, dm);
    endtask

    initial begin
        int stalls;
        #12;
        check("rst_busy", md_busy, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(4'd1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        cyc(4'd2, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MC, 1'b0);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        cyc(4'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC, 1'b0);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        cyc(4'd7, 1'b1, 32'h11, 32'd0, 1'b0);
        cyc(4'd8, 1'b1, 32'h22, 32'd0, 1'b0);
        cyc(4'd4, 1'b1, 32'd99, 32'd0, 1'b0);
        idle(DC - 1, 1'b0);
        check("divz_busy", md_busy, 1'b1);
        idle(1, 1'b0);
        check("divz_hi", hi, 32'h11);
        check("divz_lo", lo, 32'h22);

        stalls = 0;
        cyc(4'd1, 1'b1, 32'd7, 32'd9, 1'b1);
        stalls += int'(last_stall);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) cyc(4'd4, 1'b1, 32'd100, 32'd3, 1'b1);
            else        cyc(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
            stalls += int'(last_stall);
        end
        check("stall_count", stalls, 6);
        check("stall_lo", lo, 32'd63);
        check("stall_hi", hi, 32'd0);

        cyc(4'd3, 1'b1, 32'd1000, 32'd7, 1'b0);
        idle(2, 1'b0);
        e_md_op = 4'd0;
        e_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", md_busy, 1'b0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        m_left = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'd7, 1'b1, 32'h5, 32'd0, 1'b0);
        cyc(4'd5, 1'b1, 32'd0, 32'd0, 1'b0);
        check("mfhi_rdata", last_rdata, 32'h5);

        // overflow and masked writes
        cyc(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC, 1'b0);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        cyc(4'd7, 1'b0, 32'hDEAD, 32'd0, 1'b0);
        cyc(4'd9, 1'b1, 32'd3, 32'd4, 1'b0);
        idle(MC + 1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rs;
            logic [31:0] rt;
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: rt = 32'hFFFF_FFFF;
                2: rs = 32'h8000_0000;
                3: rt = $urandom_range(1, 9);
                default: ;
            endcase
            cyc(4'($urandom_range(0, 11)), ($urandom_range(0, 3) != 0), rs, rt,
                bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide execution unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the decoder's multiply/divide class flag (mult, multu, div, divu, mfhi, mflo, mthi, mtlo).
- Owns the HI/LO registers and runs multi-cycle operations with a busy counter.
- Generates the D-stage stall request for any multiply/divide-class instruction that arrives while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- e_md_op  input  4  E-stage multiply/divide opcode (encoding from package); MD_NONE when idle
- e_valid  input  1  E-stage instruction is real (not a bubble or flush)
- e_rs  input  32  forwarded rs value
- e_rt  input  32  forwarded rt value
- d_isdm  input  1  D-stage instruction is multiply/divide class
- md_start  output  1  combinational; e_valid && op in {mult, multu, div, divu[, madd, maddu]} && !busy
- md_busy  output  1  registered; operation in flight
- md_stall  output  1  combinational; d_isdm && (md_start || md_busy)
- md_rdata  output  32  combinational; HI when e_md_op==MD_MFHI, otherwise LO
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: hi=0, lo=0, md_busy=0, counter=0, latched operands/op=0. Reset is asynchronous and aborts any in-flight operation; no result is written.
- Start:
  - On a clock edge where md_start=1: latch rs, rt and op; load counter with MULT_CYCLES or DIV_CYCLES; md_busy=1 from the next cycle.
  - Each busy cycle decrements the counter.
  - On the edge where the counter reaches 1 → 0: write hi/lo and clear md_busy on that same edge.
  - Result is visible exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
- A start op presented while md_busy=1 is ignored: no relatch, no counter change. Hazard logic prevents this case; the block still defines it.
- mthi/mtlo:
  - With e_valid and !md_busy, write hi (or lo) from e_rs at the next edge, single cycle.
  - While busy, the write is ignored (the stall prevents it in practice).
- mfhi/mflo: purely combinational read of the current hi/lo; does not affect state.
- Arithmetic:
  - mult: signed 32x32 → 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 → 64; same split.
  - div: signed; lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - divu: unsigned; lo = quotient, hi = remainder.
  - Divide by zero (rt==0): hi and lo unchanged; busy timing identical to a normal div.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Counter: 4-bit down-counter; never wraps because it only loads while idle.
- e_valid=0 suppresses start and mthi/mtlo regardless of e_md_op.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined:
  - Adds ops MD_MADD and MD_MADDU: {hi,lo} += rs*rt (signed or unsigned 64-bit accumulate, wraps mod 2^64).
  - Timing is MULT_CYCLES.
  - The accumulate uses the {hi,lo} value sampled at the start edge.
- When undefined: those encodings are treated as MD_NONE (no start, no write).

Decomposition:
- Shared package holds:
  - 4-bit op encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8, MD_MADD=9, MD_MADDU=10.
  - Default cycle constants.
  - Helper function is_md_start(op).
- Sub-module md_arith: combinational 64-bit result from latched op/operands, including the divide-by-zero keep flag.
- md_unit holds the registers, counter and stall logic.

Test Plan:
- mult, rs=0xFFFFFFFE, rt=3 → md_busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div, rs=-7 (0xFFFFFFF9), rt=2 → 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, rt=0 after hi=0x11, lo=0x22 → 10 busy cycles; hi=0x11, lo=0x22 unchanged.
- mult started, d_isdm=1 on the start cycle and all busy cycles → md_stall=1 for 6 cycles, then 0; a start issued mid-busy changes nothing.
- rst_n pulled low at busy cycle 3 of a div → immediately md_busy=0, hi=lo=0; mthi rs=0x5 afterwards → hi=0x5, and mfhi gives md_rdata=0x5.
